// File: rtl/bus_arb_pkg.sv
// Shared types and widths for the two-master bus arbiter.
package bus_arb_pkg;

  localparam int unsigned BUS_ADDR_W  = 16;
  localparam int unsigned BUS_WDATA_W = 32;
  localparam int unsigned BUS_RDATA_W = 64;

  // Ownership encoding; 2'b11 is unused and recovers to ARB_IDLE.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/bus_arbiter2_if.sv
// One bus channel: request/write/address/data out, grant/read data back.
interface bus_arbiter2_if;
  import bus_arb_pkg::*;

  logic                   req;
  logic                   wr;
  logic [BUS_ADDR_W-1:0]  addr;
  logic [BUS_WDATA_W-1:0] dout;
  logic                   grant;
  logic [BUS_RDATA_W-1:0] din;

  // Side that issues transfers (a master, or the arbiter towards BUS).
  modport master (output req, wr, addr, dout, input grant, din);
  // Side that serves transfers (the arbiter towards a master, or BUS).
  modport slave  (input req, wr, addr, dout, output grant, din);

endinterface

// File: rtl/bus_arb_hold_cnt.sv
// Ownership hold counter: clear, increment, saturate at MAX_HOLD-1.
module bus_arb_hold_cnt #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic at_max
);

  localparam int unsigned    CW    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned    LIM   = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0]  LIM_V = CW'(LIM);

  logic [CW-1:0] cnt;

  // Count owned cycles; clear has priority, stop at the limit.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIM_V)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_max = (MAX_HOLD != 0) && (cnt == LIM_V);

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter in front of the BUS master port.
module bus_arbiter2
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_arbiter2_if.slave         m0,
  bus_arbiter2_if.slave         m1,
  bus_arbiter2_if.master        b,
  output logic [1:0]            arb_state
);

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic       at_max;
  logic       hold_clr;
  logic       hold_en;

  // State and last-owner registers; master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next ownership: idle tie-break on last, release handover, forced handover.
  always_comb begin
    state_nxt = ARB_IDLE;
    last_nxt  = last;
    case (state)
      ARB_IDLE: begin
        if (m0.req && m1.req) state_nxt = last ? ARB_OWN0 : ARB_OWN1;
        else if (m0.req)      state_nxt = ARB_OWN0;
        else if (m1.req)      state_nxt = ARB_OWN1;
        else                  state_nxt = ARB_IDLE;
      end
      ARB_OWN0: begin
        if (!m0.req)               state_nxt = m1.req ? ARB_OWN1 : ARB_IDLE;
        else if (m1.req && at_max) state_nxt = ARB_OWN1;
        else                       state_nxt = ARB_OWN0;
      end
      ARB_OWN1: begin
        if (!m1.req)               state_nxt = m0.req ? ARB_OWN0 : ARB_IDLE;
        else if (m0.req && at_max) state_nxt = ARB_OWN0;
        else                       state_nxt = ARB_OWN1;
      end
      default: state_nxt = ARB_IDLE;
    endcase
    if (state_nxt == ARB_OWN0) last_nxt = 1'b0;
    if (state_nxt == ARB_OWN1) last_nxt = 1'b1;
  end

  // Any state change is an entry, which restarts the hold count.
  assign hold_clr = (state_nxt != state);
  assign hold_en  = (state == ARB_OWN0) || (state == ARB_OWN1);

  bus_arb_hold_cnt #(.MAX_HOLD(MAX_HOLD)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .clr    (hold_clr),
    .en     (hold_en),
    .at_max (at_max)
  );

  // Steer the owner onto BUS and route grant/read data back to it only.
  always_comb begin
    b.req    = 1'b0;
    b.wr     = 1'b0;
    b.addr   = '0;
    b.dout   = '0;
    m0.grant = 1'b0;
    m1.grant = 1'b0;
    m0.din   = '0;
    m1.din   = '0;
    case (state)
      ARB_OWN0: begin
        b.req    = m0.req;
        b.wr     = m0.wr;
        b.addr   = m0.addr;
        b.dout   = m0.dout;
        m0.grant = b.grant;
        m0.din   = b.din;
      end
      ARB_OWN1: begin
        b.req    = m1.req;
        b.wr     = m1.wr;
        b.addr   = m1.addr;
        b.dout   = m1.dout;
        m1.grant = b.grant;
        m1.din   = b.din;
      end
      default: ;
    endcase
  end

  assign arb_state = state;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Bench for bus_arbiter2: directed literal checks plus random traffic
// compared every cycle against an ownership model, on MAX_HOLD=4 and 0.
module tb_bus_arbiter2;
  import bus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0 = 0, r1 = 0, w0 = 0, w1 = 0, bg = 0;
  logic [15:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [63:0] bdin = '0;
  logic [1:0]  st4, st0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter2_if m0_4(), m1_4(), b_4(), m0_0(), m1_0(), b_0();

  assign m0_4.req = r0;  assign m0_4.wr = w0;  assign m0_4.addr = a0;  assign m0_4.dout = d0;
  assign m1_4.req = r1;  assign m1_4.wr = w1;  assign m1_4.addr = a1;  assign m1_4.dout = d1;
  assign b_4.grant = bg; assign b_4.din = bdin;
  assign m0_0.req = r0;  assign m0_0.wr = w0;  assign m0_0.addr = a0;  assign m0_0.dout = d0;
  assign m1_0.req = r1;  assign m1_0.wr = w1;  assign m1_0.addr = a1;  assign m1_0.dout = d1;
  assign b_0.grant = bg; assign b_0.din = bdin;

  bus_arbiter2 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(rst), .m0(m0_4), .m1(m1_4), .b(b_4), .arb_state(st4));
  bus_arbiter2 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(rst), .m0(m0_0), .m1(m1_0), .b(b_0), .arb_state(st0));

  // Model: owner (-1 none), last owner, cycles owned so far, hold limit.
  int own [2]  = '{-1, -1};
  int lst [2]  = '{1, 1};
  int held[2]  = '{0, 0};
  int maxh[2]  = '{4, 0};

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic take(int k, int m);
    own[k]  = m;
    lst[k]  = m;
    held[k] = 1;
  endtask

  task automatic model_step(int k);
    logic oreq, xreq;
    if (rst) begin
      own[k] = -1; lst[k] = 1; held[k] = 0;
    end else if (own[k] < 0) begin
      if (r0 && r1) take(k, 1 - lst[k]);
      else if (r0)  take(k, 0);
      else if (r1)  take(k, 1);
    end else begin
      oreq = (own[k] == 0) ? r0 : r1;
      xreq = (own[k] == 0) ? r1 : r0;
      if (!oreq) begin
        if (xreq) take(k, 1 - own[k]);
        else own[k] = -1;
      end else if (xreq && maxh[k] != 0 && held[k] >= maxh[k]) begin
        take(k, 1 - own[k]);
      end else begin
        held[k]++;
      end
    end
  endtask

  task automatic cmp(int k, logic [1:0] st, logic br, logic bw, logic [15:0] ba,
                     logic [31:0] bd, logic g0, logic g1, logic [63:0] x0, logic [63:0] x1);
    int o = own[k];
    chk($sformatf("m%0d state", k), 64'(st), (o < 0) ? 64'd0 : 64'(o + 1));
    chk($sformatf("m%0d b_req", k),  64'(br), (o == 0) ? 64'(r0) : (o == 1) ? 64'(r1) : 64'd0);
    chk($sformatf("m%0d b_wr", k),   64'(bw), (o == 0) ? 64'(w0) : (o == 1) ? 64'(w1) : 64'd0);
    chk($sformatf("m%0d b_addr", k), 64'(ba), (o == 0) ? 64'(a0) : (o == 1) ? 64'(a1) : 64'd0);
    chk($sformatf("m%0d b_dout", k), 64'(bd), (o == 0) ? 64'(d0) : (o == 1) ? 64'(d1) : 64'd0);
    chk($sformatf("m%0d grant0", k), 64'(g0), (o == 0) ? 64'(bg) : 64'd0);
    chk($sformatf("m%0d grant1", k), 64'(g1), (o == 1) ? 64'(bg) : 64'd0);
    chk($sformatf("m%0d din0", k),   x0, (o == 0) ? bdin : 64'd0);
    chk($sformatf("m%0d din1", k),   x1, (o == 1) ? bdin : 64'd0);
  endtask

  // Advance the model at each edge and compare both DUTs just after it.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    cmp(0, st4, b_4.req, b_4.wr, b_4.addr, b_4.dout, m0_4.grant, m1_4.grant, m0_4.din, m1_4.din);
    cmp(1, st0, b_0.req, b_0.wr, b_0.addr, b_0.dout, m0_0.grant, m1_0.grant, m0_0.din, m1_0.din);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; r0 = 0; r1 = 0;
    tick(1);
    rst = 1'b0;
  endtask

  int pat[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  initial begin
    // Reset: everything zero even with BUS granting and returning data.
    bg = 1'b1; bdin = 64'h1234_5678_9ABC_DEF0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst state", 64'(st4), 64'd0);
    chk("rst b_req", 64'(b_4.req), 64'd0);
    chk("rst grant0", 64'(m0_4.grant), 64'd0);
    chk("rst din0", m0_4.din, 64'd0);

    // Single request from master 0.
    r0 = 1'b1; a0 = 16'h0010;
    tick(1);
    chk("own0 state", 64'(st4), 64'd1);
    chk("own0 b_addr", 64'(b_4.addr), 64'h10);
    chk("own0 grant0", 64'(m0_4.grant), 64'd1);
    chk("own0 grant1", 64'(m1_4.grant), 64'd0);
    bg = 1'b0; #1;
    chk("own0 grant0 follows", 64'(m0_4.grant), 64'd0);

    // Tie from idle, release handover, tie again.
    do_reset();
    r0 = 1; r1 = 1; tick(1);
    chk("tie state", 64'(st4), 64'd1);
    r0 = 0; tick(1);
    chk("handover state", 64'(st4), 64'd2);
    r1 = 0; tick(1);
    chk("release state", 64'(st4), 64'd0);
    r0 = 1; r1 = 1; tick(1);
    chk("tie2 state", 64'(st4), 64'd1);

    // Forced alternation every 4 cycles; no limit keeps master 0.
    do_reset();
    r0 = 1; r1 = 1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i < 12) chk($sformatf("alt%0d state", i), 64'(st4), 64'(pat[i]));
      chk($sformatf("nolim%0d state", i), 64'(st0), 64'd1);
    end

    // Read data to owner 1 only, then reset mid-ownership.
    do_reset();
    r1 = 1; bg = 1; bdin = 64'hDEAD_BEEF_0000_0001;
    tick(1);
    chk("own1 state", 64'(st4), 64'd2);
    chk("own1 din1", m1_4.din, 64'hDEAD_BEEF_0000_0001);
    chk("own1 din0", m0_4.din, 64'd0);
    rst = 1; tick(1);
    chk("midrst state", 64'(st4), 64'd0);
    chk("midrst b_req", 64'(b_4.req), 64'd0);
    chk("midrst grant1", 64'(m1_4.grant), 64'd0);
    chk("midrst din1", m1_4.din, 64'd0);
    rst = 0; r1 = 0;

    // Random traffic with sticky requests so holds and preemption occur.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) r0 = ~r0;
      if ($urandom_range(7) == 0) r1 = ~r1;
      w0 = 1'($urandom); w1 = 1'($urandom);
      a0 = 16'($urandom); a1 = 16'($urandom);
      d0 = $urandom; d1 = $urandom;
      bg = 1'($urandom);
      bdin = {$urandom, $urandom};
      rst = ($urandom_range(199) == 0);
      tick(1);
    end

    // Illegal encoding recovers to idle without granting.
    do_reset();
    bg = 1; tick(1);
    force dut4.state = arb_state_t'(2'b11);
    #1;
    chk("illegal state", 64'(st4), 64'd3);
    chk("illegal grant0", 64'(m0_4.grant), 64'd0);
    chk("illegal grant1", 64'(m1_4.grant), 64'd0);
    chk("illegal b_req", 64'(b_4.req), 64'd0);
    #2;
    release dut4.state;
    @(posedge clk); #2;
    chk("recover state", 64'(st4), 64'd0);
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
# bus_arbiter2

Two-master round-robin arbiter placed in front of `BUS`. It lets two independent masters share the single master port of `BUS`, for example a host interface plus a DMA/sequencer. It registers ownership, steers the owner's request, write, address and data onto the `BUS` master port, and routes `BUS` read data and grant back to the owner only. An optional hold limit forces a handover so neither master can starve the other.

## Interface
Parameters:
- `MAX_HOLD`, 16: maximum consecutive owned cycles before a forced handover while the other master is waiting; 0 disables the limit.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_req`, `m1_req`  in  1  bus request from master 0 / 1.
- `m0_wr`, `m1_wr`  in  1  write enable (1 = write).
- `m0_addr`, `m1_addr`  in  16  address.
- `m0_dout`, `m1_dout`  in  32  write data.
- `m0_grant`, `m1_grant`  out  1  grant to master 0 / 1.
- `m0_din`, `m1_din`  out  64  read data to master 0 / 1.
- `b_req`, `b_wr`  out  1  to `BUS` `m_req` / `m_wr`.
- `b_addr`  out  16  to `BUS` `m_addr`.
- `b_dout`  out  32  to `BUS` `m_dout`.
- `b_grant`  in  1  from `BUS` `m_grant`.
- `b_din`  in  64  from `BUS` `m_din`.
- `arb_state`  out  2  current state encoding, for debug.

## Operation
- States:
  - `IDLE` = 2'b00.
  - `OWN0` = 2'b01.
  - `OWN1` = 2'b10.
  - 2'b11 is illegal and recovers to `IDLE` on the next edge.
- Registers:
  - `state`.
  - `last`, the last owner (1 bit).
  - `hold_cnt`, wide enough for `MAX_HOLD`.
- Transitions from `IDLE`:
  - Only `m0_req` is high → `OWN0`.
  - Only `m1_req` is high → `OWN1`.
  - Both are high → the master with index ≠ `last`.
  - Neither is high → stay in `IDLE`.
- Transitions from `OWNx`:
  - Owner `req` is low and the other master is requesting → `OWN(other)` directly, with no idle gap.
  - Owner `req` is low and the other master is not requesting → `IDLE`.
  - Owner `req` is high, the other master is requesting, `MAX_HOLD` ≠ 0 and `hold_cnt == MAX_HOLD-1` → forced switch to `OWN(other)`.
  - Otherwise → stay in `OWNx`.
- `last` is updated to x every time `OWNx` is entered.
- `hold_cnt`:
  - Cleared to 0 on entry to any state.
  - Increments each cycle in `OWNx`.
  - Saturates at `MAX_HOLD-1`.
- Steering, combinational from `state`:
  - In `OWNx`, `b_req`, `b_wr`, `b_addr` and `b_dout` equal master x's inputs.
  - In `IDLE`, all `b_*` outputs are 0.
- `mx_grant = (state == OWNx) & b_grant`.
- `mx_din = (state == OWNx) ? b_din : 64'h0`.
- A non-owner always sees `grant = 0` and `din = 0`. Its request stays pending, with no queueing beyond the level of its `req`.

## Timing
- Reset (synchronous, `reset` high at an edge):
  - `state` ← `IDLE`, `last` ← 1 (so master 0 wins the first tie), `hold_cnt` ← 0.
  - All outputs are 0 from the cycle after that edge.
- Arbitration latency: `req` sampled high at edge N gives `state == OWNx` after edge N. `mx_grant` then follows `b_grant` combinationally in that same cycle.
- Handover latency: owner `req` drops before edge N → the new owner owns after edge N (1 cycle).
- Forced handover: the owner holds for exactly `MAX_HOLD` cycles when the other master is continuously waiting. A still-requesting preempted owner regains the bus after the other master releases or is preempted.
- Simultaneous drop of the owner and a rise of the other master's request in the same cycle → switch at the next edge.
- `reset` asserted mid-transfer: grants and `b_*` outputs drop after that edge. The `BUS` transfer is abandoned; no completion is guaranteed.
- No combinational path from `mx_req` to `mx_grant`. There is a combinational path `b_grant` → `mx_grant`, and `b_din` → `mx_din`.

## Structure
- Package `bus_arb_pkg` holds:
  - State encodings `ARB_IDLE`, `ARB_OWN0`, `ARB_OWN1`.
  - Width constants `BUS_ADDR_W` = 16, `BUS_WDATA_W` = 32, `BUS_RDATA_W` = 64.
- One sub-module, `bus_arb_hold_cnt`: the clear/increment/saturate counter, with `clk`, `reset`, `clr`, `en`, `at_max` and parameter `MAX_HOLD`.
- The next-state logic and the steering multiplexers stay in `bus_arbiter2`.

## Test plan
- Reset, then `m0_req` = 1 with `m0_addr` = 16'h0010 → after one edge: `arb_state` = 01, `b_addr` = 16'h0010, `m0_grant` = `b_grant`, `m1_grant` = 0.
- From `IDLE` after reset, both `req` rise in the same cycle → `OWN0`. On the drop of `m0_req` → `OWN1` after 1 edge. Both re-request from `IDLE` → `OWN0` (since `last` = 1).
- `MAX_HOLD` = 4, both `req` held high → owner alternates every 4 cycles: 0,0,0,0,1,1,1,1,0…
- `MAX_HOLD` = 0, both `req` high for 50 cycles → master 0 owns all 50 cycles.
- In `OWN1` with `b_din` = 64'hDEAD_BEEF_0000_0001 → `m1_din` equals it and `m0_din` = 0. Assert `reset` for one edge mid-ownership → `arb_state` = 00 and all outputs 0 on the next cycle.
- Force `state` to 2'b11 via the bench → `IDLE` after one edge, with no grant issued in that cycle.
